// File: rtl/expression_sum_sched.sv
// Round-robin scheduler sharing one serial adder between two requesters.
// Optional a+b+c tap output is enabled by defining SUM3_TAP_EN.
module expression_sum_sched #(
   parameter int WIDTH = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [1:0]         req,
   input  logic [4*WIDTH-1:0] opnd0,
   input  logic [4*WIDTH-1:0] opnd1,
   input  logic               sel0,
   input  logic               sel1,
   output logic [1:0]         gnt,
   output logic               busy,
   output logic               done,
   output logic [1:0]         ack,
   output logic [WIDTH+1:0]   sum_out
`ifdef SUM3_TAP_EN
   ,
   output logic [WIDTH+1:0]   sum3_out
`endif
);

   typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

   state_t                  state, state_nxt;
   logic [3:0][WIDTH-1:0]   opnd_q;
   logic                    sel_q;
   logic [WIDTH+1:0]        acc, acc_nxt;
   logic [1:0]              cnt;
   logic                    last;      // 1 = requester 1 was served last
   logic [1:0]              win;
   logic                    last_add;

   // On a tie the requester not served last wins.
   always_comb begin
      win = 2'b00;
      if (req[0] && (!req[1] || last)) win = 2'b01;
      else if (req[1])                 win = 2'b10;
   end

   assign acc_nxt  = acc + {2'b00, opnd_q[cnt]};
   assign last_add = (cnt == (sel_q ? 2'd1 : 2'd3));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (|req)    state_nxt = ACC;
         ACC:     if (last_add) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      ack  = 2'b00;
      if (state != IDLE) busy = 1'b1;
      if (state == DONE) begin
         done = 1'b1;
         ack  = gnt;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         gnt      <= '0;
         opnd_q   <= '0;
         sel_q    <= 1'b0;
         acc      <= '0;
         cnt      <= '0;
         last     <= 1'b1;
         sum_out  <= '0;
`ifdef SUM3_TAP_EN
         sum3_out <= '0;
`endif
      end else begin
         case (state)
            IDLE: if (|req) begin
               gnt    <= win;
               opnd_q <= win[1] ? opnd1 : opnd0;
               sel_q  <= win[1] ? sel1 : sel0;
               acc    <= '0;
               cnt    <= '0;
            end
            ACC: begin
               acc <= acc_nxt;
               cnt <= cnt + 2'd1;
               if (last_add) sum_out <= acc_nxt;
`ifdef SUM3_TAP_EN
               if (!sel_q && cnt == 2'd2) sum3_out <= acc_nxt;
`endif
            end
            DONE: begin
               gnt  <= '0;
               last <= gnt[1];
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_expression_sum_sched.sv
// Self-checking bench for expression_sum_sched: vector table, scoreboard queue
// checked on each done pulse, and hand-written multi-cycle corner cases.
module tb_expression_sum_sched;
   localparam int W = 4;

   typedef struct {
      logic [5:0] sum;
      logic [5:0] sum3;
      logic [1:0] ack;
   } exp_t;

   typedef struct {
      bit          idx;
      logic [15:0] op;
      bit          sel;
      logic [5:0]  sum;
      logic [5:0]  sum3;
      int          lat;
   } vec_t;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [1:0]    req = '0;
   logic [15:0]   opnd0 = '0, opnd1 = '0;
   logic          sel0 = 1'b0, sel1 = 1'b0;
   logic [1:0]    gnt, ack;
   logic          busy, done;
   logic [5:0]    sum_out;
   logic [5:0]    sum3_out;

   int n_cmp = 0;
   int n_err = 0;
   int ack_cnt = 0;
   exp_t q[$];
   vec_t vecs[5];

   expression_sum_sched #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .req(req), .opnd0(opnd0), .opnd1(opnd1),
      .sel0(sel0), .sel1(sel1), .gnt(gnt), .busy(busy), .done(done),
      .ack(ack), .sum_out(sum_out)
`ifdef SUM3_TAP_EN
      , .sum3_out(sum3_out)
`endif
   );
`ifndef SUM3_TAP_EN
   assign sum3_out = '0;
`endif

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp_v);
      n_cmp++;
      if (act != exp_v) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
      end
   endtask

   // Scoreboard: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (reset && done) begin
         ack_cnt++;
         if (q.size() == 0) begin
            chk("unexpected_done", 1, 0);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("sum_out", int'(sum_out), int'(e.sum));
            chk("ack", int'(ack), int'(e.ack));
`ifdef SUM3_TAP_EN
            chk("sum3_out", int'(sum3_out), int'(e.sum3));
`endif
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Called 1 time unit after a posedge with the DUT idle.
   task automatic run_one(input bit idx, input logic [15:0] op, input bit s,
                          input logic [5:0] es, input logic [5:0] es3,
                          input int lat, input bit corrupt);
      int cyc;
      logic [1:0] oh;
      oh = idx ? 2'b10 : 2'b01;
      if (idx) begin opnd1 = op; sel1 = s; end
      else     begin opnd0 = op; sel0 = s; end
      req[idx] = 1'b1;
      q.push_back('{sum: es, sum3: es3, ack: oh});
      cyc = 0;
      do begin
         tick();
         cyc++;
         if (cyc == 1) begin
            chk("gnt_after_grant", int'(gnt), int'(oh));
            if (corrupt) begin opnd0 = '0; sel0 = ~s; end
         end
      end while (!done && cyc < 20);
      chk("done_latency", cyc, lat);
      req[idx] = 1'b0;
      tick();
      chk("done_one_cycle", int'(done), 0);
      chk("gnt_released", int'(gnt), 0);
   endtask

   initial begin
      vecs[0] = '{idx: 0, op: 16'hFFFF, sel: 0, sum: 60, sum3: 45, lat: 5};
      vecs[1] = '{idx: 1, op: 16'h9935, sel: 1, sum: 8,  sum3: 45, lat: 3};
      vecs[2] = '{idx: 0, op: 16'h4321, sel: 0, sum: 10, sum3: 6,  lat: 5};
      vecs[3] = '{idx: 1, op: 16'h00FF, sel: 1, sum: 30, sum3: 6,  lat: 3};
      vecs[4] = '{idx: 1, op: 16'h5678, sel: 0, sum: 26, sum3: 21, lat: 5};

      repeat (2) tick();
      chk("rst_gnt", int'(gnt), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_ack", int'(ack), 0);
      chk("rst_sum", int'(sum_out), 0);
      chk("rst_sum3", int'(sum3_out), 0);
      reset = 1'b1;
      tick();

      foreach (vecs[i])
         run_one(vecs[i].idx, vecs[i].op, vecs[i].sel, vecs[i].sum, vecs[i].sum3,
                 vecs[i].lat, 1'b0);

      // Contention: both held, grants must alternate 0,1,0 with 6-cycle spacing.
      begin
         int t, tprev, guard;
         opnd0 = 16'h1111; opnd1 = 16'h2222; sel0 = 0; sel1 = 0;
         q.push_back('{sum: 4, sum3: 3, ack: 2'b01});
         q.push_back('{sum: 8, sum3: 6, ack: 2'b10});
         q.push_back('{sum: 4, sum3: 3, ack: 2'b01});
         req = 2'b11;
         t = 0; tprev = 0;
         for (int k = 0; k < 3; k++) begin
            guard = 0;
            do begin tick(); t++; guard++; end while (!done && guard < 30);
            chk("rr_done_seen", int'(done), 1);
            chk("rr_gnt", int'(gnt), (k % 2 == 0) ? 1 : 2);
            if (k > 0) chk("rr_spacing", t - tprev, 6);
            tprev = t;
         end
         req = 2'b00;
         tick();
      end

      // Operand/sel change after grant must be ignored.
      run_one(0, 16'h1234, 0, 10, 9, 5, 1'b1);

      // Reset during ACC: outputs clear at once, no ack for the aborted job.
      opnd0 = 16'hFFFF; sel0 = 0; req = 2'b01;
      repeat (3) tick();
      chk("pre_rst_busy", int'(busy), 1);
      reset = 1'b0;
      #1;
      chk("midrst_gnt", int'(gnt), 0);
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_done", int'(done), 0);
      chk("midrst_ack", int'(ack), 0);
      chk("midrst_sum", int'(sum_out), 0);
      chk("midrst_sum3", int'(sum3_out), 0);
      req = 2'b00;
      tick();
      reset = 1'b1;
      tick();
      run_one(0, 16'h2222, 0, 8, 6, 5, 1'b0);

      // req0 held one cycle past ack starts a second transaction.
      begin
         int base, guard;
         base = ack_cnt;
         opnd0 = 16'h0076; sel0 = 1;
         q.push_back('{sum: 13, sum3: 6, ack: 2'b01});
         q.push_back('{sum: 13, sum3: 6, ack: 2'b01});
         req = 2'b01;
         guard = 0;
         do begin tick(); guard++; end while (!done && guard < 20);
         chk("hold_first_done", int'(done), 1);
         tick();
         chk("hold_idle_gap", int'(busy), 0);
         tick();
         chk("hold_regrant", int'(gnt), 1);
         req = 2'b00;
         guard = 0;
         do begin tick(); guard++; end while (!done && guard < 20);
         chk("hold_second_done", int'(done), 1);
         tick();
         chk("hold_ack_count", ack_cnt - base, 2);
      end

      repeat (3) tick();
      chk("queue_drained", q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end
endmodule
